// File: rtl/rx_ds_pkg.sv
// rx_ds_pkg: definitions shared by the DS character receiver.
//   rxState_t    - receiver FSM state encoding
//   CODE_*       - two-bit control codes {c1,c0}
//   NULL_PATTERN - hunt window contents for ESC tail + FCT (P=0);
//                  the oldest bit is in the MSB, the newest in the LSB
package rx_ds_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    PAR  = 2'd1,
    FLAG = 2'd2,
    BITS = 2'd3
  } rxState_t;

  localparam logic [1:0] CODE_FCT = 2'b00;
  localparam logic [1:0] CODE_EOP = 2'b01;
  localparam logic [1:0] CODE_EEP = 2'b10;
  localparam logic [1:0] CODE_ESC = 2'b11;

  // Time order 1,1,1,0,1,0,0: ESC's F,c1,c0 followed by FCT's P,F,c1,c0.
  localparam logic [6:0] NULL_PATTERN = 7'b1110100;

endpackage

// File: rtl/ds_bit_recover.sv
// ds_bit_recover: resynchronises the DS data/strobe pair into rxClk and
// recovers one bit per d^s transition.
//   rxClk     - receive clock
//   rxReset   - synchronous active-high reset
//   d, s      - asynchronous DS data and strobe lines
//   bitStrobe - high for one cycle when synchronised d^s changed
//   bitData   - synchronised d, valid while bitStrobe is high
module ds_bit_recover
  import rx_ds_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic rxClk,
  input  logic rxReset,
  input  logic d,
  input  logic s,
  output logic bitStrobe,
  output logic bitData
);

  logic [SYNC_STAGES-1:0] dSync;
  logic [SYNC_STAGES-1:0] sSync;
  logic                   xorPrev;
  logic                   dSyncd;
  logic                   sSyncd;

  assign dSyncd = dSync[SYNC_STAGES-1];
  assign sSyncd = sSync[SYNC_STAGES-1];

  always_ff @(posedge rxClk) begin
    if (rxReset) begin
      dSync   <= '0;
      sSync   <= '0;
      xorPrev <= 1'b0;
    end else begin
      dSync[0] <= d;
      sSync[0] <= s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dSync[i] <= dSync[i-1];
        sSync[i] <= sSync[i-1];
      end
      // extra stage: previous d^s, used to spot the transition
      xorPrev <= dSyncd ^ sSyncd;
    end
  end

  assign bitStrobe = (dSyncd ^ sSyncd) ^ xorPrev;
  assign bitData   = dSyncd;

endmodule

// File: rtl/rx_ds_char.sv
// rx_ds_char: DS link character receiver. Acquires alignment on a NULL,
// then decodes data characters, EOP/EEP, FCT and time codes, checking
// odd parity and escape sequences and watching for link silence.
//   rxClk, rxReset  - clock, synchronous active-high reset
//   d, s            - DS data / strobe lines
//   charValid       - one-cycle pulse: charData/charIsCtrl hold a character
//   charIsCtrl      - 1 for EOP/EEP (charData[1:0] = code)
//   charData        - data byte or control code
//   fctPulse        - one-cycle pulse per received FCT
//   timeValid       - one-cycle pulse: timeData holds a time code
//   timeData        - time-code value
//   gotNull         - level, link aligned since the last NULL
//   parityErr, escErr, disconnect - one-cycle error pulses
module rx_ds_char
  import rx_ds_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DISC_CYCLES = 510
) (
  input  logic       rxClk,
  input  logic       rxReset,
  input  logic       d,
  input  logic       s,
  output logic       charValid,
  output logic       charIsCtrl,
  output logic [7:0] charData,
  output logic       fctPulse,
  output logic       timeValid,
  output logic [7:0] timeData,
  output logic       gotNull,
  output logic       parityErr,
  output logic       escErr,
  output logic       disconnect
);

  logic        bitStrobe;
  logic        bitData;
  rxState_t    state;
  logic [6:0]  window;
  logic [6:0]  winNext;
  logic        pBit;
  logic        fBit;
  logic        bitsPar;   // parity of the previous character's data/code bits
  logic        escFlag;
  logic [3:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic [7:0]  byteNext;
  logic [1:0]  codeNext;
  logic        discArmed;
  logic [15:0] discCnt;
  logic        discFire;

  ds_bit_recover #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bitRecover (
    .rxClk    (rxClk),
    .rxReset  (rxReset),
    .d        (d),
    .s        (s),
    .bitStrobe(bitStrobe),
    .bitData  (bitData)
  );

  // Data arrives LSB first and shifts in from the top; codes arrive c1 then c0.
  assign winNext  = {window[5:0], bitData};
  assign byteNext = {bitData, shiftReg[7:1]};
  assign codeNext = {shiftReg[7], bitData};
  assign discFire = discArmed && !bitStrobe && (discCnt == 16'(DISC_CYCLES - 1));

  // Silence watchdog: armed by any edge, disarmed once it fires.
  always_ff @(posedge rxClk) begin
    if (rxReset) begin
      discArmed <= 1'b0;
      discCnt   <= '0;
    end else if (bitStrobe) begin
      discArmed <= 1'b1;
      discCnt   <= '0;
    end else if (discFire) begin
      discArmed <= 1'b0;
      discCnt   <= '0;
    end else if (discArmed) begin
      discCnt <= discCnt + 16'd1;
    end
  end

  always_ff @(posedge rxClk) begin
    if (rxReset) begin
      state      <= HUNT;
      window     <= '0;
      pBit       <= 1'b0;
      fBit       <= 1'b0;
      bitsPar    <= 1'b0;
      escFlag    <= 1'b0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      gotNull    <= 1'b0;
      charValid  <= 1'b0;
      charIsCtrl <= 1'b0;
      charData   <= '0;
      fctPulse   <= 1'b0;
      timeValid  <= 1'b0;
      timeData   <= '0;
      parityErr  <= 1'b0;
      escErr     <= 1'b0;
      disconnect <= 1'b0;
    end else begin
      charValid  <= 1'b0;
      fctPulse   <= 1'b0;
      timeValid  <= 1'b0;
      parityErr  <= 1'b0;
      escErr     <= 1'b0;
      disconnect <= 1'b0;
      if (discFire) begin
        disconnect <= 1'b1;
        gotNull    <= 1'b0;
        escFlag    <= 1'b0;
        window     <= '0;
        state      <= HUNT;
      end else if (bitStrobe) begin
        unique case (state)
          HUNT: begin
            window <= winNext;
            if (winNext == NULL_PATTERN) begin
              // the NULL's FCT code (00) is the preceding-bits parity term
              state   <= PAR;
              gotNull <= 1'b1;
              escFlag <= 1'b0;
              bitsPar <= 1'b0;
              window  <= '0;
            end
          end
          PAR: begin
            pBit  <= bitData;
            state <= FLAG;
          end
          FLAG: begin
            if ((pBit ^ bitData ^ bitsPar) == 1'b0) begin
              parityErr <= 1'b1;
              gotNull   <= 1'b0;
              escFlag   <= 1'b0;
              window    <= '0;
              state     <= HUNT;
            end else begin
              fBit    <= bitData;
              bitsPar <= 1'b0;
              bitCnt  <= bitData ? 4'd2 : 4'd8;
              state   <= BITS;
            end
          end
          BITS: begin
            bitsPar  <= bitsPar ^ bitData;
            shiftReg <= byteNext;
            bitCnt   <= bitCnt - 4'd1;
            if (bitCnt == 4'd1) begin
              if (!fBit) begin
                state <= PAR;
                if (escFlag) begin
                  timeValid <= 1'b1;
                  timeData  <= byteNext;
                  escFlag   <= 1'b0;
                end else begin
                  charValid  <= 1'b1;
                  charIsCtrl <= 1'b0;
                  charData   <= byteNext;
                end
              end else if (escFlag) begin
                escFlag <= 1'b0;
                if (codeNext == CODE_FCT) begin
                  state <= PAR;          // ESC+FCT is a NULL: silently consumed
                end else begin
                  escErr  <= 1'b1;
                  gotNull <= 1'b0;
                  window  <= '0;
                  state   <= HUNT;
                end
              end else begin
                state <= PAR;
                unique case (codeNext)
                  CODE_FCT: fctPulse <= 1'b1;
                  CODE_ESC: escFlag  <= 1'b1;
                  default: begin
                    charValid  <= 1'b1;
                    charIsCtrl <= 1'b1;
                    charData   <= {6'b0, codeNext};
                  end
                endcase
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_ds_char.sv
// tb_rx_ds_char: directed bench for rx_ds_char. A DS line driver encodes
// characters with correct odd parity; a pulse monitor counts output
// pulses and logs received characters.
module tb_rx_ds_char;

  localparam int DISC = 16;

  logic       rxClk = 1'b0;
  logic       rxReset;
  logic       d;
  logic       s;
  logic       charValid;
  logic       charIsCtrl;
  logic [7:0] charData;
  logic       fctPulse;
  logic       timeValid;
  logic [7:0] timeData;
  logic       gotNull;
  logic       parityErr;
  logic       escErr;
  logic       disconnect;

  always #5 rxClk = ~rxClk;

  rx_ds_char #(
    .SYNC_STAGES(2),
    .DISC_CYCLES(DISC)
  ) dut (
    .rxClk     (rxClk),
    .rxReset   (rxReset),
    .d         (d),
    .s         (s),
    .charValid (charValid),
    .charIsCtrl(charIsCtrl),
    .charData  (charData),
    .fctPulse  (fctPulse),
    .timeValid (timeValid),
    .timeData  (timeData),
    .gotNull   (gotNull),
    .parityErr (parityErr),
    .escErr    (escErr),
    .disconnect(disconnect)
  );

  int nChecks = 0;
  int nFails  = 0;

  // pulse monitor
  int         charCnt  = 0;
  int         fctCnt   = 0;
  int         timeCnt  = 0;
  int         parCnt   = 0;
  int         escCnt   = 0;
  int         discCnt  = 0;
  int         multiCnt = 0;
  logic [7:0] charLog [0:63];
  logic       ctrlLog [0:63];

  always @(negedge rxClk) begin
    if (charValid) begin
      charLog[charCnt % 64] <= charData;
      ctrlLog[charCnt % 64] <= charIsCtrl;
      charCnt <= charCnt + 1;
    end
    if (fctPulse)   fctCnt  <= fctCnt + 1;
    if (timeValid)  timeCnt <= timeCnt + 1;
    if (parityErr)  parCnt  <= parCnt + 1;
    if (escErr)     escCnt  <= escCnt + 1;
    if (disconnect) discCnt <= discCnt + 1;
    if ((32'(charValid) + 32'(fctPulse) + 32'(timeValid)) > 1) multiCnt <= multiCnt + 1;
  end

  // DS driver: one bit every 4 cycles, exactly one line toggles per bit
  logic prevPar = 1'b0;

  task automatic settle(input int n);
    repeat (n) @(negedge rxClk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    @(negedge rxClk);
    if (b == d) s = ~s;
    d = b;
    repeat (3) @(negedge rxClk);
  endtask

  task automatic sendData(input logic [7:0] val, input logic corruptP);
    sendBit(~(1'b0 ^ prevPar) ^ corruptP);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(val[i]);
    prevPar = ^val;
  endtask

  task automatic sendCtrl(input logic [1:0] code);
    sendBit(~(1'b1 ^ prevPar));
    sendBit(1'b1);
    sendBit(code[1]);
    sendBit(code[0]);
    prevPar = ^code;
  endtask

  task automatic sendNull();
    sendCtrl(2'b11);
    sendCtrl(2'b00);
  endtask

  task automatic test_reset();
    int d0;
    rxReset = 1'b1;
    d = 1'b0;
    s = 1'b0;
    repeat (3) @(negedge rxClk);
    rxReset = 1'b0;
    d0 = discCnt;
    settle(100);
    nChecks++;
    if ({charValid, charIsCtrl, charData, fctPulse, timeValid, timeData,
         gotNull, parityErr, escErr, disconnect} !== 23'd0) begin
      nFails++;
      $display("FAIL reset_outputs: got %h want 0", {charValid, charIsCtrl, charData, fctPulse,
               timeValid, timeData, gotNull, parityErr, escErr, disconnect});
    end
    nChecks++;
    if (discCnt - d0 !== 0) begin
      nFails++;
      $display("FAIL idle_no_disconnect: got %0d pulses want 0", discCnt - d0);
    end
  endtask

  task automatic test_null_data();
    int c0, f0;
    c0 = charCnt;
    f0 = fctCnt;
    sendNull();
    settle(4);
    nChecks++;
    if (gotNull !== 1'b1) begin
      nFails++;
      $display("FAIL null_acquire: gotNull=%0b want 1", gotNull);
    end
    sendNull();
    settle(4);
    nChecks++;
    if (charCnt - c0 !== 0 || fctCnt - f0 !== 0) begin
      nFails++;
      $display("FAIL null_no_pulse: char=%0d fct=%0d want 0 0", charCnt - c0, fctCnt - f0);
    end
    sendData(8'hA5, 1'b0);
    settle(4);
    nChecks++;
    if (charCnt - c0 !== 1) begin
      nFails++;
      $display("FAIL data_count: got %0d want 1", charCnt - c0);
    end
    nChecks++;
    if (charData !== 8'hA5 || charIsCtrl !== 1'b0) begin
      nFails++;
      $display("FAIL data_value: got %h ctrl=%0b want a5 ctrl=0", charData, charIsCtrl);
    end
  endtask

  task automatic test_ctrl();
    int c0, f0;
    c0 = charCnt;
    f0 = fctCnt;
    sendCtrl(2'b00);
    settle(4);
    nChecks++;
    if (fctCnt - f0 !== 1 || charCnt - c0 !== 0) begin
      nFails++;
      $display("FAIL fct_pulse: fct=%0d char=%0d want 1 0", fctCnt - f0, charCnt - c0);
    end
    sendCtrl(2'b01);
    sendCtrl(2'b10);
    settle(4);
    nChecks++;
    if (charCnt - c0 !== 2) begin
      nFails++;
      $display("FAIL eop_eep_count: got %0d want 2", charCnt - c0);
    end
    nChecks++;
    if (charLog[c0 % 64] !== 8'h01 || ctrlLog[c0 % 64] !== 1'b1) begin
      nFails++;
      $display("FAIL eop_value: got %h ctrl=%0b want 01 ctrl=1", charLog[c0 % 64], ctrlLog[c0 % 64]);
    end
    nChecks++;
    if (charLog[(c0 + 1) % 64] !== 8'h02 || ctrlLog[(c0 + 1) % 64] !== 1'b1) begin
      nFails++;
      $display("FAIL eep_value: got %h ctrl=%0b want 02 ctrl=1",
               charLog[(c0 + 1) % 64], ctrlLog[(c0 + 1) % 64]);
    end
    nChecks++;
    if (fctCnt - f0 !== 1) begin
      nFails++;
      $display("FAIL fct_once: got %0d want 1", fctCnt - f0);
    end
  endtask

  task automatic test_escape();
    int c0, t0, e0;
    c0 = charCnt;
    t0 = timeCnt;
    e0 = escCnt;
    sendCtrl(2'b11);
    sendData(8'h3F, 1'b0);
    settle(4);
    nChecks++;
    if (timeCnt - t0 !== 1 || timeData !== 8'h3F) begin
      nFails++;
      $display("FAIL time_code: count=%0d data=%h want 1 3f", timeCnt - t0, timeData);
    end
    nChecks++;
    if (charCnt - c0 !== 0 || charData !== 8'h02) begin
      nFails++;
      $display("FAIL time_no_char: count=%0d charData=%h want 0 02", charCnt - c0, charData);
    end
    sendCtrl(2'b11);
    sendCtrl(2'b11);
    settle(4);
    nChecks++;
    if (escCnt - e0 !== 1 || gotNull !== 1'b0) begin
      nFails++;
      $display("FAIL esc_err: count=%0d gotNull=%0b want 1 0", escCnt - e0, gotNull);
    end
    sendNull();
    settle(4);
    nChecks++;
    if (gotNull !== 1'b1) begin
      nFails++;
      $display("FAIL esc_reacquire: gotNull=%0b want 1", gotNull);
    end
  endtask

  task automatic test_parity();
    int c0, p0;
    c0 = charCnt;
    p0 = parCnt;
    sendData(8'h5A, 1'b1);
    settle(4);
    nChecks++;
    if (parCnt - p0 !== 1 || charCnt - c0 !== 0) begin
      nFails++;
      $display("FAIL parity_err: perr=%0d char=%0d want 1 0", parCnt - p0, charCnt - c0);
    end
    nChecks++;
    if (gotNull !== 1'b0) begin
      nFails++;
      $display("FAIL parity_drop_null: gotNull=%0b want 0", gotNull);
    end
    sendNull();
    settle(4);
    nChecks++;
    if (gotNull !== 1'b1 || parCnt - p0 !== 1) begin
      nFails++;
      $display("FAIL parity_reacquire: gotNull=%0b perr=%0d want 1 1", gotNull, parCnt - p0);
    end
  endtask

  task automatic test_disconnect_reset();
    int d0;
    d0 = discCnt;
    settle(3 * DISC);
    nChecks++;
    if (discCnt - d0 !== 1 || gotNull !== 1'b0) begin
      nFails++;
      $display("FAIL disconnect: pulses=%0d gotNull=%0b want 1 0", discCnt - d0, gotNull);
    end
    settle(40);
    nChecks++;
    if (discCnt - d0 !== 1) begin
      nFails++;
      $display("FAIL disconnect_once: pulses=%0d want 1", discCnt - d0);
    end
    sendNull();
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    @(negedge rxClk);
    rxReset = 1'b1;
    @(negedge rxClk);
    #1;
    nChecks++;
    if ({charValid, charIsCtrl, charData, fctPulse, timeValid, timeData,
         gotNull, parityErr, escErr, disconnect} !== 23'd0) begin
      nFails++;
      $display("FAIL midchar_reset: got %h want 0", {charValid, charIsCtrl, charData, fctPulse,
               timeValid, timeData, gotNull, parityErr, escErr, disconnect});
    end
    rxReset = 1'b0;
    sendNull();
    settle(4);
    nChecks++;
    if (gotNull !== 1'b1) begin
      nFails++;
      $display("FAIL reset_reacquire: gotNull=%0b want 1", gotNull);
    end
    nChecks++;
    if (multiCnt !== 0) begin
      nFails++;
      $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", multiCnt);
    end
  endtask

  initial begin
    rxReset = 1'b1;
    d = 1'b0;
    s = 1'b0;
    test_reset();
    test_null_data();
    test_ctrl();
    test_escape();
    test_parity();
    test_disconnect_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/rx_ds_char.md
RX_DS_CHAR -- requirements
Module: rx_ds_char

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on d and s (legal 1..4).
REQ-002 Parameter DISC_CYCLES, default 510, rxClk cycles without a d^s edge before disconnect is declared (legal 8..65535).
REQ-003 Ports: rxClk input 1, sole clock; rxReset input 1, synchronous active-high reset; d input 1, DS data line; s input 1, DS strobe line.
REQ-004 Outputs: charValid 1, one-cycle character pulse; charIsCtrl 1, 1 = EOP/EEP; charData 8, data byte (ctrl: [1:0] = code, [7:2] = 0); fctPulse 1, FCT received; timeValid 1, time-code pulse; timeData 8, time-code value.
REQ-005 Outputs: gotNull 1, link aligned (level); parityErr 1, escErr 1, disconnect 1, one-cycle error pulses.

Function
REQ-006 d and s SHALL each pass through SYNC_STAGES flops, then one more stage; an edge is declared when synchronised d^s differs from its previous value. Each edge yields one bit equal to synchronised d at that edge.
REQ-007 Character format (time order): P, F, then 8 data bits LSB first when F=0, or 2 code bits c1,c0 when F=1. Code {c1,c0}: FCT=00, EOP=01, EEP=10, ESC=11.
REQ-008 States: HUNT, PAR, FLAG, BITS. HUNT shifts bits into a 7-bit window. On the window matching 1,1,1,0,1,0,0 in time order (ESC tail + FCT with P=0), SHALL go to PAR and set gotNull=1; no output pulses for that NULL.
REQ-009 PAR captures P -> FLAG; FLAG captures F and loads bit count 8 or 2 -> BITS; BITS counts down; last bit -> PAR with the character completed.
REQ-010 Parity: P of character n plus F of character n plus the data/code bits of character n-1 SHALL have odd parity. After NULL acquisition the preceding-bits term is the FCT code (0,0). Violation SHALL pulse parityErr, discard the character, clear gotNull, enter HUNT.
REQ-011 Completion decode, outputs asserted the cycle after the last bit's edge is detected: data -> charValid, charIsCtrl=0. EOP/EEP -> charValid, charIsCtrl=1. FCT -> fctPulse. ESC -> arms escape flag, no pulse.
REQ-012 With escape armed: FCT -> NULL (no pulse, flag cleared); data -> timeValid with timeData=byte, no charValid; ESC/EOP/EEP -> escErr pulse, clear gotNull, HUNT.
REQ-013 Disconnect counter SHALL be armed by the first edge after reset or after a disconnect, clear on every edge, and increment otherwise. Reaching DISC_CYCLES SHALL pulse disconnect once, clear gotNull, escape flag and window, enter HUNT, disarm.
REQ-014 Simultaneous completion and error: error wins; no character/time/fct pulse in that cycle. At most one of charValid, fctPulse, timeValid high per cycle.
REQ-015 charData/charIsCtrl/timeData SHALL hold their last values between pulses.

Reset
REQ-016 rxReset SHALL, synchronously and at any point mid-character, force HUNT; clear the window, synchroniser flops, counters, escape flag and parity accumulator; drive every output to 0. The disconnect counter SHALL be disarmed.

Structure
REQ-017 Shared package rx_ds_pkg SHALL hold the state encoding, control-code constants (FCT, EOP, EEP, ESC) and the NULL hunt pattern.
REQ-018 One sub-module, ds_bit_recover (synchroniser, edge detect, bit/strobe output), SHALL be instantiated. The rest resides in rx_ds_char.

Verification
REQ-019 Reset, then drive idle lines for 100 cycles -> all outputs 0, no disconnect (counter not armed).
REQ-020 Send NULL, NULL -> gotNull=1 after first NULL, no charValid or fctPulse. Then data 0xA5 -> one charValid, charData=0xA5, charIsCtrl=0.
REQ-021 After acquisition, send FCT, then EOP, then EEP -> fctPulse once. Then charValid, charIsCtrl=1, charData=0x01; then charData=0x02.
REQ-022 Send ESC + data 0x3F -> timeValid once, timeData=0x3F, no charValid. Send ESC, ESC -> escErr once, gotNull=0.
REQ-023 Corrupt P of a data character -> parityErr once, no charValid, gotNull=0. A following NULL restores gotNull=1.
REQ-024 Stop edges for DISC_CYCLES cycles (parameter set to 16) -> exactly one disconnect pulse and gotNull=0. Assert rxReset mid-character -> all outputs 0 the next cycle.
